verificador_paridade_serial: RTL and testbench
==============================================

# verificador_paridade_serial

Serial parity checker: the receiving end of the parity-generation path. Accepts a frame of N_BITS data bits, LSB first, followed by one parity bit. Reassembles the data word and reports whether the received parity bit matches the configured parity. Sits after the serial link, before the word-level consumer.

## Interface
- N_BITS, 8, data bits per frame (≥ 2)
- PARIDADE_IMPAR, 0, 0 = even parity (total ones incl. parity bit even), 1 = odd parity
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- bit_in  input  1  serial bit, sampled when bit_valido=1
- bit_valido  input  1  bit_in is valid this cycle (one bit accepted per high cycle)
- inicio  input  1  qualifies an accepted bit as data bit 0 of a new frame
- dado_out  output  N_BITS  last complete data word (bit 0 = first received)
- dado_valido  output  1  one-cycle pulse: dado_out/erro_paridade updated
- erro_paridade  output  1  1 = parity mismatch on frame flagged by dado_valido
- ocupado  output  1  frame in progress (state ≠ OCIOSO)

## Operation
- States: OCIOSO, DADOS, PARIDADE.
- OCIOSO: an accepted bit with inicio=1 → stored as data bit 0, acc = bit_in, cnt = 1, go to DADOS. An accepted bit with inicio=0 is ignored.
- DADOS: an accepted bit with inicio=0 → stored at position cnt, acc ^= bit_in, cnt++. When cnt reaches N_BITS → PARIDADE.
- PARIDADE: the next accepted bit with inicio=0 is the parity bit. erro = acc ^ bit_in ^ PARIDADE_IMPAR. Load dado_out and erro_paridade, pulse dado_valido, return to OCIOSO.
- Resync: in DADOS or PARIDADE, an accepted bit with inicio=1 aborts the current frame with no output. That bit is taken as data bit 0 of a new frame (cnt = 1, acc = bit_in, state DADOS).
- Cycles with bit_valido=0 are gaps. No state change, no timeout.
- inicio with bit_valido=0 has no effect.
- Internal shift/assembly register is separate from dado_out. dado_out and erro_paridade hold their value until the next completed frame.
- cnt width = $clog2(N_BITS+1). Counter never wraps; it is cleared on frame start.

## Timing
- Reset values: dado_out = 0, dado_valido = 0, erro_paridade = 0, ocupado = 0, state OCIOSO, cnt = 0, acc = 0.
- Reset mid-frame discards the partial frame immediately. No dado_valido is produced.
- Latency: dado_valido is high the cycle after the clock edge that accepts the parity bit (registered output), for exactly 1 cycle.
- Back-to-back frames: a new inicio bit may be accepted in the cycle immediately after the parity bit. That cycle coincides with the dado_valido pulse; both are handled.
- ocupado rises the cycle after the inicio bit is accepted. It falls the cycle after the parity bit is accepted, aligned with dado_valido.
- Minimum frame duration: N_BITS+1 consecutive cycles with bit_valido=1.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared include paridade_defs.vh holds:
  - state encodings ST_OCIOSO=2'd0, ST_DADOS=2'd1, ST_PARIDADE=2'd2
  - PARIDADE_PAR=1'b0 and PARIDADE_IMPAR_V=1'b1, shared with the generator side.
- One sub-module, acumulador_paridade: 1-bit running-XOR register with load/enable/clear, clk/rst ports. Instantiated once.
- FSM, counter, and assembly register live in the top module.

## Test plan
- Even parity, N_BITS=8:
  - Stimulus: inicio on first bit; data 0xA5 sent LSB first (1,0,1,0,0,1,0,1); parity bit 0.
  - Response: dado_out=0xA5, erro_paridade=0, dado_valido high for 1 cycle, one cycle after the parity bit is accepted.
- Same frame with parity bit 1 → dado_out=0xA5, erro_paridade=1.
- PARIDADE_IMPAR=1:
  - data 0x07 with parity 0 → erro_paridade=0.
  - data 0x00 with parity 0 → erro_paridade=1.
- Gaps and stray bits:
  - Frame 0x3C, parity 0, with random 0–3 idle cycles between bits → dado_out=0x3C, erro_paridade=0.
  - Stray accepted bits in OCIOSO without inicio → ignored, ocupado stays 0.
- Resync:
  - Stimulus: inicio followed by 3 data bits, then inicio again starting frame 0x81 with parity 0.
  - Response: exactly one dado_valido, with dado_out=0x81, erro_paridade=0.
- Reset mid-frame:
  - Stimulus: assert rst after 5 data bits.
  - Response: ocupado=0 and dado_out=0 at once, no dado_valido. Next frame 0xFF with parity 0 → erro_paridade=0.
  - Back-to-back frames 0x12 then 0x34, both with correct parity → two dado_valido pulses N_BITS+1 cycles apart, no dropped bits.

Source files
------------

// File: rtl/verificador_paridade_serial_pkg.sv
// Shared definitions for the serial parity path: FSM encodings and parity modes.
package verificador_paridade_serial_pkg;
   localparam logic [1:0] ST_OCIOSO   = 2'd0;
   localparam logic [1:0] ST_DADOS    = 2'd1;
   localparam logic [1:0] ST_PARIDADE = 2'd2;

   // Parity mode values, common to the generator and the checker.
   localparam logic PARIDADE_PAR     = 1'b0;
   localparam logic PARIDADE_IMPAR_V = 1'b1;

   typedef enum logic [1:0] {
      OCIOSO   = ST_OCIOSO,
      DADOS    = ST_DADOS,
      PARIDADE = ST_PARIDADE
   } estado_t;
endpackage

// File: rtl/verificador_paridade_serial_acumulador.sv
// 1-bit running-XOR register. Priority: clear, then load, then accumulate.
module acumulador_paridade (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_load,
   input  logic i_en,
   input  logic i_bit,
   output logic o_acc
);
   logic r_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_acc <= 1'b0;
      else if (i_clr)
         r_acc <= 1'b0;
      else if (i_load)
         r_acc <= i_bit;
      else if (i_en)
         r_acc <= r_acc ^ i_bit;
   end

   assign o_acc = r_acc;
endmodule

// File: rtl/verificador_paridade_serial.sv
// Serial parity checker: N_BITS data bits LSB first plus one parity bit; registered word and error flag.
module verificador_paridade_serial
   import verificador_paridade_serial_pkg::*;
#(
   parameter int   N_BITS         = 8,
   parameter logic PARIDADE_IMPAR = PARIDADE_PAR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_valido,
   input  logic              inicio,
   output logic [N_BITS-1:0] dado_out,
   output logic              dado_valido,
   output logic              erro_paridade,
   output logic              ocupado
);
   localparam int CW = $clog2(N_BITS + 1);
   localparam logic [CW-1:0] CNT_ULT = CW'(N_BITS - 1);

   estado_t           r_estado;
   estado_t           w_prox;
   logic [CW-1:0]     r_cnt;
   logic [N_BITS-1:0] r_desloc;
   logic [N_BITS-1:0] r_dado;
   logic              r_dado_vld;
   logic              r_erro;
   logic              r_ocupado;
   logic              w_inicia;
   logic              w_desloca;
   logic              w_conclui;
   logic              w_acc;

   // inicio wins in every state: it either opens a frame or resyncs onto a new one.
   always_comb begin
      w_prox    = r_estado;
      w_inicia  = 1'b0;
      w_desloca = 1'b0;
      w_conclui = 1'b0;
      if (bit_valido && inicio) begin
         w_inicia = 1'b1;
         w_prox   = DADOS;
      end else if (bit_valido) begin
         case (r_estado)
            DADOS: begin
               w_desloca = 1'b1;
               if (r_cnt == CNT_ULT)
                  w_prox = PARIDADE;
            end
            PARIDADE: begin
               w_conclui = 1'b1;
               w_prox    = OCIOSO;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado  <= OCIOSO;
         r_ocupado <= 1'b0;
      end else begin
         r_estado  <= w_prox;
         r_ocupado <= (w_prox != OCIOSO);
      end
   end

   // Right shift: after N_BITS bits the first one received lands in bit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_desloc <= '0;
      end else if (w_inicia) begin
         r_cnt    <= CW'(1);
         r_desloc <= {bit_in, r_desloc[N_BITS-1:1]};
      end else if (w_desloca) begin
         r_cnt    <= r_cnt + CW'(1);
         r_desloc <= {bit_in, r_desloc[N_BITS-1:1]};
      end
   end

   acumulador_paridade u_acumulador (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_conclui),
      .i_load (w_inicia),
      .i_en   (w_desloca),
      .i_bit  (bit_in),
      .o_acc  (w_acc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dado     <= '0;
         r_erro     <= 1'b0;
         r_dado_vld <= 1'b0;
      end else begin
         r_dado_vld <= w_conclui;
         if (w_conclui) begin
            r_dado <= r_desloc;
            r_erro <= w_acc ^ bit_in ^ (PARIDADE_IMPAR == PARIDADE_IMPAR_V);
         end
      end
   end

   assign dado_out      = r_dado;
   assign dado_valido   = r_dado_vld;
   assign erro_paridade = r_erro;
   assign ocupado       = r_ocupado;
endmodule

// File: tb/tb_verificador_paridade_serial.sv
// Bench: an even-parity and an odd-parity checker share one serial stimulus stream.
module tb_verificador_paridade_serial;
   localparam int N = 8;

   typedef struct {
      logic [N-1:0] dado;
      logic         erro_par;
      int           ciclo;
   } esperado_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         bit_in;
   logic         bit_valido;
   logic         inicio;
   logic [N-1:0] e_dado, o_dado;
   logic         e_vld, o_vld, e_erro, o_erro, e_ocup, o_ocup;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   esperado_t q_e[$];
   esperado_t q_o[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   verificador_paridade_serial #(.N_BITS(N), .PARIDADE_IMPAR(1'b0)) dut_par (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valido(bit_valido), .inicio(inicio),
      .dado_out(e_dado), .dado_valido(e_vld), .erro_paridade(e_erro), .ocupado(e_ocup));

   verificador_paridade_serial #(.N_BITS(N), .PARIDADE_IMPAR(1'b1)) dut_impar (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valido(bit_valido), .inicio(inicio),
      .dado_out(o_dado), .dado_valido(o_vld), .erro_paridade(o_erro), .ocupado(o_ocup));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, input logic ini);
      @(posedge clk); #1;
      bit_in = b; bit_valido = 1'b1; inicio = ini;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         bit_valido = 1'b0; inicio = 1'b0; bit_in = $urandom_range(1, 0);
      end
   endtask

   // Expected result is queued while the parity bit is driven; it is accepted at the
   // next edge and the pulse is due in the cycle after that edge.
   task automatic send_frame(input logic [N-1:0] d, input logic p, input int gap_max);
      esperado_t ex;
      for (int i = 0; i < N; i++) begin
         send_bit(d[i], i == 0);
         if (gap_max > 0) idle($urandom_range(gap_max, 0));
      end
      send_bit(p, 1'b0);
      ex.dado     = d;
      ex.erro_par = 1'($countones(d)) ^ p;
      ex.ciclo    = cyc + 1;
      q_e.push_back(ex);
      ex.erro_par = ~ex.erro_par;
      q_o.push_back(ex);
   endtask

   always @(negedge clk) begin
      esperado_t ex;
      if (e_vld) begin
         if (q_e.size() == 0) chk("par_pulso_inesperado", 32'(e_vld), 32'd0);
         else begin
            ex = q_e.pop_front();
            chk("par_dado", 32'(e_dado), 32'(ex.dado));
            chk("par_erro", 32'(e_erro), 32'(ex.erro_par));
            chk("par_ciclo", 32'(cyc), 32'(ex.ciclo));
            chk("par_ocupado_cai", 32'(e_ocup), 32'(ex.ciclo == -1));
         end
      end
      if (o_vld) begin
         if (q_o.size() == 0) chk("impar_pulso_inesperado", 32'(o_vld), 32'd0);
         else begin
            ex = q_o.pop_front();
            chk("impar_dado", 32'(o_dado), 32'(ex.dado));
            chk("impar_erro", 32'(o_erro), 32'(ex.erro_par));
            chk("impar_ciclo", 32'(cyc), 32'(ex.ciclo));
         end
      end
   end

   initial begin
      rst = 1'b1; bit_in = 1'b0; bit_valido = 1'b0; inicio = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_dado", 32'(e_dado), 32'd0);
      chk("reset_vld", 32'(e_vld), 32'd0);
      chk("reset_erro", 32'({e_erro, o_erro}), 32'd0);
      chk("reset_ocupado", 32'({e_ocup, o_ocup}), 32'd0);
      rst = 1'b0;
      idle(2);

      send_frame(8'hA5, 1'b0, 0); idle(3);
      send_frame(8'hA5, 1'b1, 0); idle(3);
      send_frame(8'h07, 1'b0, 0); idle(3);
      send_frame(8'h00, 1'b0, 0); idle(3);
      send_frame(8'h3C, 1'b0, 3); idle(3);

      // Stray bits without inicio while idle must be ignored.
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      idle(1);
      chk("stray_ocupado", 32'({e_ocup, o_ocup}), 32'd0);
      chk("stray_hold_dado", 32'(e_dado), 32'h3C);

      // Resync: abandoned frame produces nothing, the restarted one completes.
      send_bit(1'b1, 1'b1);
      idle(1);
      chk("ocupado_sobe", 32'({e_ocup, o_ocup}), 32'b11);
      send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
      send_frame(8'h81, 1'b0, 0); idle(3);

      // Reset after 5 data bits clears everything immediately.
      send_bit(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      idle(1);
      #2 rst = 1'b1;
      #1;
      chk("rst_meio_ocupado", 32'({e_ocup, o_ocup}), 32'd0);
      chk("rst_meio_dado", 32'(e_dado), 32'd0);
      chk("rst_meio_dado_impar", 32'(o_dado), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      idle(2);
      send_frame(8'hFF, 1'b0, 0); idle(3);

      // Back-to-back frames: pulses exactly N+1 cycles apart.
      send_frame(8'h12, 1'b0, 0);
      send_frame(8'h34, 1'b1, 0);
      idle(6);

      chk("fila_par_vazia", 32'(q_e.size()), 32'd0);
      chk("fila_impar_vazia", 32'(q_o.size()), 32'd0);
      chk("hold_dado_final", 32'(e_dado), 32'h34);
      chk("hold_vld_baixo", 32'({e_vld, o_vld}), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
